hex_print_tx: RTL

- Output-formatting stage directly downstream of the debug command units (D/R/I commands).
- Accepts a 32-bit word plus a format type over a req/ack handshake, converts it to ASCII hex characters MSB-nibble first, and appends a separator.
- Streams the characters one byte at a time over the valid/ready byte interface that feeds the UART transmitter.

---
 rtl/hex_print_tx_if.sv | 25 ++
 rtl/hex_print_tx.sv | 119 +++++++++++
 2 files changed

// File: rtl/hex_print_tx_if.sv
// Word-in / byte-out bundle of the hex print stage: a req/ack word request
// from the command unit and a valid/ready byte stream to the UART transmitter.
interface hex_print_tx_if;
  // Word side: req_tx is a level request; ack_tx pulses once per printed word.
  // Byte side: a byte moves on a rising edge where vld_tx=1 and rdy_tx=1;
  // while vld_tx=1 and rdy_tx=0 the byte and vld_tx hold stable, and vld_tx
  // never depends combinationally on rdy_tx.
  logic [31:0] dout_tx;
  logic        type_tx;
  logic        req_tx;
  logic        ack_tx;
  logic [7:0]  d_tx;
  logic        vld_tx;
  logic        rdy_tx;

  modport slave (
    input  dout_tx, type_tx, req_tx, rdy_tx,
    output ack_tx, d_tx, vld_tx
  );

  modport master (
    output dout_tx, type_tx, req_tx, rdy_tx,
    input  ack_tx, d_tx, vld_tx
  );
endinterface

// File: rtl/hex_print_tx.sv
// Formats a 32-bit word as ASCII hex (MSB nibble first) plus a space or CR LF
// separator, streaming one byte at a time toward the UART transmitter.
module hex_print_tx #(
  parameter int DIGITS = 8,
  parameter bit UPPER  = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  hex_print_tx_if.slave bus,
  output logic [2:0]    state_dbg
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DIGIT   = 3'd1,
    SEP1    = 3'd2,
    SEP2    = 3'd3,
    DONE    = 3'd4,
    WAITLOW = 3'd5
  } state_t;

  localparam logic [2:0] LAST = 3'(DIGITS - 1);

  state_t      state, state_nxt;
  logic [2:0]  cnt, cnt_nxt;
  logic [31:0] word, word_nxt;
  logic        crlf, crlf_nxt;
  logic [7:0]  d_nxt;
  logic        vld_nxt, ack_nxt;
  logic        xfer;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return (UPPER ? 8'h41 : 8'h61) + {4'h0, n} - 8'd10;
  endfunction

  // Digit k prints nibble DIGITS-1-k, so the most significant printed nibble goes first.
  function automatic logic [3:0] nibble(input logic [31:0] w, input logic [2:0] k);
    logic [2:0] idx;
    idx = LAST - k;
    return w[{idx, 2'b00} +: 4];
  endfunction

  assign xfer      = bus.vld_tx & bus.rdy_tx;
  assign state_dbg = state;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    word_nxt  = word;
    crlf_nxt  = crlf;
    case (state)
      IDLE: begin
        if (bus.req_tx) begin
          word_nxt  = bus.dout_tx;
          crlf_nxt  = bus.type_tx;
          cnt_nxt   = 3'd0;
          state_nxt = DIGIT;
        end
      end
      DIGIT: begin
        if (xfer) begin
          if (cnt == LAST) state_nxt = SEP1;
          else             cnt_nxt   = cnt + 3'd1;
        end
      end
      SEP1:    if (xfer) state_nxt = crlf ? SEP2 : DONE;
      SEP2:    if (xfer) state_nxt = DONE;
      DONE:    state_nxt = WAITLOW;
      WAITLOW: if (!bus.req_tx) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they leave the flops cleanly;
  // a stalled byte re-decodes to the same value because nothing advances.
  always_comb begin
    d_nxt   = 8'h00;
    vld_nxt = 1'b0;
    ack_nxt = 1'b0;
    case (state_nxt)
      DIGIT: begin
        vld_nxt = 1'b1;
        d_nxt   = hex_char(nibble(word_nxt, cnt_nxt));
      end
      SEP1: begin
        vld_nxt = 1'b1;
        d_nxt   = crlf_nxt ? 8'h0D : 8'h20;
      end
      SEP2: begin
        vld_nxt = 1'b1;
        d_nxt   = 8'h0A;
      end
      DONE:    ack_nxt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      word       <= 32'h0;
      crlf       <= 1'b0;
      bus.d_tx   <= 8'h00;
      bus.vld_tx <= 1'b0;
      bus.ack_tx <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      word       <= word_nxt;
      crlf       <= crlf_nxt;
      bus.d_tx   <= d_nxt;
      bus.vld_tx <= vld_nxt;
      bus.ack_tx <= ack_nxt;
    end
  end

endmodule
